// File: rtl/sign_led_driver_pkg.sv
// Shared types and width helpers for the sign LED driver.
package sign_led_driver_pkg;

   // Flash sequencer states; the unused encoding 2'd3 recovers to StIdle.
   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StOn   = 2'd1,
      StOff  = 2'd2
   } state_e;

   // Bits needed for a counter running 0..div-1 (div >= 2).
   function automatic int unsigned div_cnt_width(input int unsigned div);
      return (div <= 2) ? 1 : $clog2(div);
   endfunction

   // Bits needed for a phase timer loaded with up to max(a, b) - 1.
   function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m <= 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/sign_led_driver_tick_divider.sv
// Free-running cycle divider: pulses tick_o every DIV cycles, restartable via clr_i.
module sign_led_driver_tick_divider
   import sign_led_driver_pkg::*;
#(
   parameter int unsigned DIV = 100_000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   output logic tick_o
);

   localparam int unsigned CntW = div_cnt_width(DIV);
   localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   assign tick_o = (cnt_q == CntLast);

   // Next count: restart on clear or wrap after the terminal count.
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clr_i || tick_o) begin
         cnt_d = '0;
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/sign_led_driver.sv
// Turns single-cycle event pulses into fixed-length LED flashes separated by dark gaps,
// queueing events that arrive while a flash is running.
module sign_led_driver
   import sign_led_driver_pkg::*;
#(
   parameter int unsigned DIV       = 100_000,
   parameter int unsigned ON_TICKS  = 200,
   parameter int unsigned OFF_TICKS = 100,
   parameter int unsigned CNT_W     = 3
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             sign_i,
   output logic             led_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] pending_o,
   output logic             overflow_o
);

   localparam int unsigned TimerW = timer_width(ON_TICKS, OFF_TICKS);
   localparam logic [TimerW-1:0] OnLoad  = TimerW'(ON_TICKS - 1);
   localparam logic [TimerW-1:0] OffLoad = TimerW'(OFF_TICKS - 1);
   localparam logic [CNT_W-1:0]  PendMax = {CNT_W{1'b1}};

   state_e            state_q, state_d;
   logic [TimerW-1:0] timer_q, timer_d;
   logic [CNT_W-1:0]  pend_q, pend_d;
   logic              ovf_q, ovf_d;
   logic              led_q, led_d;
   logic              tick;
   logic              clr;
   logic              start;

   // Divider restarts on every state change and is parked at zero while idle.
   assign clr = (state_q == StIdle) || (state_d != state_q);

   sign_led_driver_tick_divider #(
      .DIV (DIV)
   ) u_tick_divider (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr_i  (clr),
      .tick_o (tick)
   );

   // FSM next state and phase timer; a phase ends on the tick seen with the timer at zero.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      start   = 1'b0;
      case (state_q)
         StIdle: begin
            if (pend_q != '0) begin
               start   = 1'b1;
               state_d = StOn;
               timer_d = OnLoad;
            end
         end
         StOn: begin
            if (tick) begin
               if (timer_q == '0) begin
                  state_d = StOff;
                  timer_d = OffLoad;
               end else begin
                  timer_d = timer_q - 1'b1;
               end
            end
         end
         StOff: begin
            if (tick) begin
               if (timer_q == '0) begin
                  state_d = StIdle;
               end else begin
                  timer_d = timer_q - 1'b1;
               end
            end
         end
         default: begin
            state_d = StIdle;
            timer_d = '0;
         end
      endcase
   end

   // Pending queue depth and sticky overflow; a coincident sign and start cancel out.
   always_comb begin
      pend_d = pend_q;
      ovf_d  = ovf_q;
      if (sign_i && !start) begin
         if (pend_q == PendMax) begin
            ovf_d = 1'b1;
         end else begin
            pend_d = pend_q + 1'b1;
         end
      end else if (start && !sign_i) begin
         pend_d = pend_q - 1'b1;
      end
   end

   // LED is registered from the next state so it tracks the ON phase exactly.
   always_comb begin
      led_d = (state_d == StOn);
   end

   // State, timer, queue and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         timer_q <= '0;
         pend_q  <= '0;
         ovf_q   <= 1'b0;
         led_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
         led_q   <= led_d;
      end
   end

   assign led_o      = led_q;
   assign busy_o     = (state_q != StIdle);
   assign pending_o  = pend_q;
   assign overflow_o = ovf_q;

endmodule

// File: tb/tb_sign_led_driver.sv
// Directed bench for sign_led_driver with DIV=10, ON_TICKS=3, OFF_TICKS=2, CNT_W=2.
module tb_sign_led_driver;

   localparam int unsigned DIV       = 10;
   localparam int unsigned ON_TICKS  = 3;
   localparam int unsigned OFF_TICKS = 2;
   localparam int unsigned CNT_W     = 2;

   logic             clk;
   logic             rst;
   logic             sign;
   logic             led;
   logic             busy;
   logic [CNT_W-1:0] pending;
   logic             overflow;

   int checks   = 0;
   int failures = 0;

   sign_led_driver #(
      .DIV       (DIV),
      .ON_TICKS  (ON_TICKS),
      .OFF_TICKS (OFF_TICKS),
      .CNT_W     (CNT_W)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .sign_i     (sign),
      .led_o      (led),
      .busy_o     (busy),
      .pending_o  (pending),
      .overflow_o (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock edge and settle before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic step_n(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Step n cycles counting rising edges of led.
   task automatic watch(input int n, output int rises);
      logic prev;
      rises = 0;
      prev  = led;
      for (int i = 0; i < n; i++) begin
         step();
         if (led && !prev) rises++;
         prev = led;
      end
   endtask

   // Global safety net in case something stalls.
   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      int cnt;
      int rises;
      int ph [0:10];

      rst  = 1'b1;
      sign = 1'b0;
      #1;

      // 1. Reset then quiet idle.
      step_n(3);
      chk("rst_led", int'(led), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_pending", int'(pending), 0);
      chk("rst_overflow", int'(overflow), 0);
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (led || busy || pending != 0 || overflow) bad++;
      end
      chk("idle_quiet", bad, 0);

      // 2. Single pulse: pending at t+1, led at t+2 for 30 cycles, 20-cycle gap.
      sign = 1'b1;
      step();
      sign = 1'b0;
      chk("t2_pend_t1", int'(pending), 1);
      chk("t2_led_t1", int'(led), 0);
      step();
      chk("t2_led_t2", int'(led), 1);
      chk("t2_pend_t2", int'(pending), 0);
      chk("t2_busy_t2", int'(busy), 1);
      cnt = 1;
      for (int i = 0; i < 100; i++) begin
         step();
         if (led) cnt++;
         else break;
      end
      chk("t2_on_len", cnt, 30);
      cnt = 1;
      for (int i = 0; i < 100; i++) begin
         step();
         if (busy && !led) cnt++;
         else break;
      end
      chk("t2_off_len", cnt, 20);
      chk("t2_busy_t52", int'(busy), 0);

      // 3. Three pulses five cycles apart.
      for (int i = 0; i <= 10; i++) begin
         sign = (i % 5 == 0);
         step();
         ph[i] = int'(pending);
      end
      sign = 1'b0;
      chk("t3_pend_e1", ph[0], 1);
      chk("t3_pend_e2", ph[1], 0);
      chk("t3_pend_e6", ph[5], 1);
      chk("t3_pend_e11", ph[10], 2);
      step_n(41);
      chk("t3_idle_e52_busy", int'(busy), 0);
      chk("t3_idle_e52_pend", int'(pending), 2);
      step();
      chk("t3_f2_led", int'(led), 1);
      chk("t3_f2_pend", int'(pending), 1);
      step_n(29);
      chk("t3_f2_last_on", int'(led), 1);
      step();
      chk("t3_f2_off", int'(led), 0);
      step_n(20);
      chk("t3_idle_e103_busy", int'(busy), 0);
      step();
      chk("t3_f3_led", int'(led), 1);
      chk("t3_f3_pend", int'(pending), 0);
      step_n(50);
      chk("t3_done_busy", int'(busy), 0);

      // 4. Five pulses: one starts a flash, four more saturate the queue at 3.
      sign = 1'b1;
      step();
      sign = 1'b0;
      step();
      chk("t4_led", int'(led), 1);
      sign = 1'b1;
      step_n(3);
      chk("t4_pend_sat", int'(pending), 3);
      chk("t4_ovf_before", int'(overflow), 0);
      step();
      sign = 1'b0;
      chk("t4_pend_hold", int'(pending), 3);
      chk("t4_ovf_set", int'(overflow), 1);
      watch(200, rises);
      chk("t4_more_flashes", rises, 3);
      chk("t4_pend_end", int'(pending), 0);
      chk("t4_busy_end", int'(busy), 0);
      chk("t4_ovf_sticky", int'(overflow), 1);

      // 5. sign coincident with the start cycle keeps pending at 1.
      sign = 1'b1;
      step();
      step();
      sign = 1'b0;
      chk("t5_led", int'(led), 1);
      chk("t5_pend", int'(pending), 1);
      watch(120, rises);
      chk("t5_second_flash", rises, 1);
      chk("t5_pend_end", int'(pending), 0);

      // 6. Reset at cycle 15 of ON with two events queued.
      sign = 1'b1;
      step();
      sign = 1'b0;
      step();
      sign = 1'b1;
      step_n(2);
      sign = 1'b0;
      step_n(12);
      chk("t6_led_pre", int'(led), 1);
      chk("t6_pend_pre", int'(pending), 2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t6_led", int'(led), 0);
      chk("t6_busy", int'(busy), 0);
      chk("t6_pend", int'(pending), 0);
      chk("t6_ovf", int'(overflow), 0);
      watch(100, rises);
      chk("t6_no_flash", rises, 0);
      chk("t6_busy_end", int'(busy), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
